// File: rtl/systolic_ctrl_param_if.sv
// Handshake and control bundle between a host and the systolic array controller.
// The host drives start/tile count/result-ready; the controller drives the array controls.
interface systolic_ctrl_param_if #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int ADDR_W = 4,
  parameter int LAT_W  = 4,
  parameter int TILE_W = 4
);
  logic                   startSys;
  logic [TILE_W-1:0]      numTiles;
  logic                   resReady;
  logic [ROWS*COLS-1:0]   rstnPsum;
  logic                   rstnPipe;
  logic                   rstnAddr;
  logic                   addrInc;
  logic [ADDR_W-1:0]      addr;
  logic [LAT_W-1:0]       latCnt;
  logic                   resValid;
  logic [TILE_W-1:0]      tileIdx;
  logic                   busy;
  logic                   done;

  modport master (
    output startSys, numTiles, resReady,
    input  rstnPsum, rstnPipe, rstnAddr, addrInc, addr, latCnt,
           resValid, tileIdx, busy, done
  );

  modport slave (
    input  startSys, numTiles, resReady,
    output rstnPsum, rstnPipe, rstnAddr, addrInc, addr, latCnt,
           resValid, tileIdx, busy, done
  );
endinterface

// File: rtl/systolic_ctrl_param.sv
// Tile sequencer for a ROWS x COLS systolic array: feeds K operand cycles, waits for
// the skewed wavefront to drain, then hands each tile result off with a valid/ready handshake.
module systolic_ctrl_param #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int K      = 4,
  parameter int ADDR_W = 4,
  parameter int LAT_W  = 4,
  parameter int TILE_W = 4
) (
  input  logic                 clk,
  input  logic                 rstSys,
  systolic_ctrl_param_if.slave bus
);

  localparam int DRAIN_CYC = ROWS + COLS - 2;
  localparam int CYC_W     = $clog2(K + ROWS + COLS) + 1;
  localparam logic [TILE_W:0] IDX_ONE = 1;

  typedef enum logic [2:0] {IDLE, FEED, DRAIN, RESULT, DONE} state_t;

  state_t              state, state_nxt;
  logic [CYC_W-1:0]    tile_cycle;
  logic [TILE_W-1:0]   tile_idx;
  logic [TILE_W-1:0]   tiles_cap;
  logic [ADDR_W-1:0]   addr;
  logic                last_tile;
  logic                active;
  logic [ROWS*COLS-1:0] psum_n;
  logic [LAT_W-1:0]    lat;

  assign last_tile = ({1'b0, tile_idx} + IDX_ONE) >= {1'b0, tiles_cap};

  always_ff @(posedge clk) begin
    if (rstSys) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (bus.startSys) state_nxt = FEED;
      FEED:   if (tile_cycle == CYC_W'(K - 1))
                state_nxt = (DRAIN_CYC > 0) ? DRAIN : RESULT;
      DRAIN:  if (tile_cycle == CYC_W'(K + DRAIN_CYC - 1)) state_nxt = RESULT;
      RESULT: if (bus.resReady) state_nxt = last_tile ? DONE : FEED;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address keeps running across tiles of one run; it only returns to 0 between runs.
  always_ff @(posedge clk) begin
    if (rstSys) begin
      tile_cycle <= '0;
      tile_idx   <= '0;
      addr       <= '0;
    end else begin
      case (state)
        IDLE: begin
          tile_cycle <= '0;
          tile_idx   <= '0;
          addr       <= '0;
          if (bus.startSys)
            tiles_cap <= (bus.numTiles == '0) ? TILE_W'(1) : bus.numTiles;
        end
        FEED: begin
          tile_cycle <= tile_cycle + CYC_W'(1);
          addr       <= addr + ADDR_W'(1);
        end
        DRAIN: tile_cycle <= tile_cycle + CYC_W'(1);
        RESULT: begin
          if (bus.resReady && !last_tile) begin
            tile_cycle <= '0;
            tile_idx   <= tile_idx + TILE_W'(1);
          end
        end
        DONE: begin
          tile_cycle <= '0;
          tile_idx   <= '0;
          addr       <= '0;
        end
        default: tile_cycle <= '0;
      endcase
    end
  end

  // PE(r,c) sees its first operand r+c cycles into the tile, so its psum clear rides that diagonal.
  always_comb begin
    active = (state == FEED) || (state == DRAIN) || (state == RESULT);
    psum_n = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (tile_cycle == CYC_W'(r + c)) psum_n[r*COLS + c] = 1'b0;
    if (!active) psum_n = '0;
    lat = '0;
    if (state == DRAIN) lat = LAT_W'(tile_cycle - CYC_W'(K));
  end

  assign bus.rstnPsum = psum_n;
  assign bus.rstnPipe = active;
  assign bus.rstnAddr = active;
  assign bus.addrInc  = (state == FEED);
  assign bus.addr     = addr;
  assign bus.latCnt   = lat;
  assign bus.resValid = (state == RESULT);
  assign bus.tileIdx  = tile_idx;
  assign bus.busy     = active;
  assign bus.done     = (state == DONE);

endmodule

// File: tb/tb_systolic_ctrl_param.sv
// Directed bench for systolic_ctrl_param: default geometry plus 1x1/K=1 and 2x8 variants.
module tb_systolic_ctrl_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  systolic_ctrl_param_if #(.ROWS(4), .COLS(4), .ADDR_W(4), .LAT_W(4), .TILE_W(4)) ifa ();
  systolic_ctrl_param_if #(.ROWS(1), .COLS(1), .ADDR_W(4), .LAT_W(4), .TILE_W(4)) ifb ();
  systolic_ctrl_param_if #(.ROWS(2), .COLS(8), .ADDR_W(4), .LAT_W(4), .TILE_W(4)) ifc ();

  systolic_ctrl_param #(.ROWS(4), .COLS(4), .K(4), .ADDR_W(4), .LAT_W(4), .TILE_W(4))
    dut_a (.clk(clk), .rstSys(rst), .bus(ifa));
  systolic_ctrl_param #(.ROWS(1), .COLS(1), .K(1), .ADDR_W(4), .LAT_W(4), .TILE_W(4))
    dut_b (.clk(clk), .rstSys(rst), .bus(ifb));
  systolic_ctrl_param #(.ROWS(2), .COLS(8), .K(4), .ADDR_W(4), .LAT_W(4), .TILE_W(4))
    dut_c (.clk(clk), .rstSys(rst), .bus(ifc));

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a(input int n);
    ifa.numTiles = 4'(n);
    ifa.startSys = 1'b1;
    tick();
    ifa.startSys = 1'b0;
  endtask

  task automatic chk_reset_a(input string tag);
    chk_eq({tag, " rstnPsum"}, 32'(ifa.rstnPsum), 32'h0);
    chk_eq({tag, " rstnPipe"}, 32'(ifa.rstnPipe), 32'h0);
    chk_eq({tag, " rstnAddr"}, 32'(ifa.rstnAddr), 32'h0);
    chk_eq({tag, " addrInc"},  32'(ifa.addrInc),  32'h0);
    chk_eq({tag, " addr"},     32'(ifa.addr),     32'h0);
    chk_eq({tag, " latCnt"},   32'(ifa.latCnt),   32'h0);
    chk_eq({tag, " resValid"}, 32'(ifa.resValid), 32'h0);
    chk_eq({tag, " tileIdx"},  32'(ifa.tileIdx),  32'h0);
    chk_eq({tag, " busy"},     32'(ifa.busy),     32'h0);
    chk_eq({tag, " done"},     32'(ifa.done),     32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    ifa.startSys = 0; ifa.numTiles = 0; ifa.resReady = 0;
    ifb.startSys = 0; ifb.numTiles = 0; ifb.resReady = 0;
    ifc.startSys = 0; ifc.numTiles = 0; ifc.resReady = 0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk_reset_a("reset");

    // Single tile, default geometry, ready always high
    ifa.resReady = 1'b1;
    start_a(1);
    for (int t = 0; t <= 10; t++) begin
      chk_eq($sformatf("one addrInc t%0d", t), 32'(ifa.addrInc), 32'(t < 4));
      chk_eq($sformatf("one addr t%0d", t), 32'(ifa.addr), (t < 4) ? t : 4);
      chk_eq($sformatf("one latCnt t%0d", t), 32'(ifa.latCnt), (t >= 4 && t < 10) ? t - 4 : 0);
      chk_eq($sformatf("one resValid t%0d", t), 32'(ifa.resValid), 32'(t == 10));
      chk_eq($sformatf("one busy t%0d", t), 32'(ifa.busy), 32'h1);
      if (t == 0)  chk_eq("psum t0",  32'(ifa.rstnPsum), 32'hFFFE);
      if (t == 1)  chk_eq("psum t1",  32'(ifa.rstnPsum), 32'hFFED);
      if (t == 6)  chk_eq("psum t6",  32'(ifa.rstnPsum), 32'h7FFF);
      if (t == 10) chk_eq("psum t10", 32'(ifa.rstnPsum), 32'hFFFF);
      if (t < 10) tick();
    end
    tick();
    chk_eq("one done",      32'(ifa.done),     32'h1);
    chk_eq("one done busy", 32'(ifa.busy),     32'h0);
    chk_eq("one done psum", 32'(ifa.rstnPsum), 32'h0);
    chk_eq("one done rstnAddr", 32'(ifa.rstnAddr), 32'h0);
    tick();
    chk_eq("one idle done", 32'(ifa.done), 32'h0);
    chk_eq("one idle addr", 32'(ifa.addr), 32'h0);

    // Three tiles with backpressure on tile 0; numTiles changes after capture
    ifa.resReady = 1'b0;
    start_a(3);
    ifa.numTiles = 4'd1;
    repeat (10) tick();
    for (int i = 0; i < 5; i++) begin
      chk_eq($sformatf("bp resValid w%0d", i), 32'(ifa.resValid), 32'h1);
      chk_eq($sformatf("bp addr w%0d", i),     32'(ifa.addr),     32'h4);
      chk_eq($sformatf("bp tileIdx w%0d", i),  32'(ifa.tileIdx),  32'h0);
      chk_eq($sformatf("bp psum w%0d", i),     32'(ifa.rstnPsum), 32'hFFFF);
      tick();
    end
    ifa.resReady = 1'b1;
    chk_eq("bp resValid w5", 32'(ifa.resValid), 32'h1);
    tick();
    chk_eq("t1 tileIdx",  32'(ifa.tileIdx),  32'h1);
    chk_eq("t1 psum",     32'(ifa.rstnPsum), 32'hFFFE);
    chk_eq("t1 addr",     32'(ifa.addr),     32'h4);
    chk_eq("t1 resValid", 32'(ifa.resValid), 32'h0);
    repeat (10) tick();
    chk_eq("t1 res valid", 32'(ifa.resValid), 32'h1);
    chk_eq("t1 res addr",  32'(ifa.addr),     32'h8);
    chk_eq("t1 res done",  32'(ifa.done),     32'h0);
    tick();
    chk_eq("t2 tileIdx", 32'(ifa.tileIdx), 32'h2);
    repeat (10) tick();
    chk_eq("t2 res valid", 32'(ifa.resValid), 32'h1);
    chk_eq("t2 res addr",  32'(ifa.addr),     32'hC);
    chk_eq("t2 res idx",   32'(ifa.tileIdx),  32'h2);
    tick();
    chk_eq("multi done", 32'(ifa.done), 32'h1);
    tick();
    chk_eq("multi after done", 32'(ifa.done),    32'h0);
    chk_eq("multi idle busy",  32'(ifa.busy),    32'h0);
    chk_eq("multi idle idx",   32'(ifa.tileIdx), 32'h0);

    // numTiles=0 runs one tile; start during DRAIN is ignored
    start_a(0);
    repeat (5) tick();
    chk_eq("zero latCnt t5", 32'(ifa.latCnt), 32'h1);
    ifa.startSys = 1'b1;
    tick();
    ifa.startSys = 1'b0;
    repeat (4) tick();
    chk_eq("zero resValid", 32'(ifa.resValid), 32'h1);
    chk_eq("zero tileIdx",  32'(ifa.tileIdx),  32'h0);
    tick();
    chk_eq("zero done", 32'(ifa.done), 32'h1);
    tick();
    chk_eq("zero idle busy", 32'(ifa.busy), 32'h0);
    tick();
    chk_eq("zero stays idle", 32'(ifa.busy), 32'h0);

    // Reset in DRAIN with start asserted the same cycle
    start_a(2);
    repeat (6) tick();
    chk_eq("abort pre latCnt", 32'(ifa.latCnt), 32'h2);
    rst = 1'b1;
    ifa.startSys = 1'b1;
    tick();
    rst = 1'b0;
    ifa.startSys = 1'b0;
    chk_reset_a("abort");
    tick();
    chk_eq("abort no done", 32'(ifa.done), 32'h0);
    chk_eq("abort idle",    32'(ifa.busy), 32'h0);
    start_a(1);
    chk_eq("restart tileIdx", 32'(ifa.tileIdx), 32'h0);
    chk_eq("restart addr",    32'(ifa.addr),    32'h0);
    chk_eq("restart addrInc", 32'(ifa.addrInc), 32'h1);
    repeat (10) tick();
    chk_eq("restart resValid", 32'(ifa.resValid), 32'h1);
    tick();
    chk_eq("restart done", 32'(ifa.done), 32'h1);

    // 1x1 array, K=1: no drain phase
    ifb.resReady = 1'b1;
    ifb.numTiles = 4'd1;
    ifb.startSys = 1'b1;
    tick();
    ifb.startSys = 1'b0;
    chk_eq("b t0 addrInc",  32'(ifb.addrInc),  32'h1);
    chk_eq("b t0 psum",     32'(ifb.rstnPsum), 32'h0);
    chk_eq("b t0 resValid", 32'(ifb.resValid), 32'h0);
    chk_eq("b t0 busy",     32'(ifb.busy),     32'h1);
    tick();
    chk_eq("b t1 resValid", 32'(ifb.resValid), 32'h1);
    chk_eq("b t1 addr",     32'(ifb.addr),     32'h1);
    chk_eq("b t1 addrInc",  32'(ifb.addrInc),  32'h0);
    chk_eq("b t1 psum",     32'(ifb.rstnPsum), 32'h1);
    tick();
    chk_eq("b done", 32'(ifb.done), 32'h1);
    tick();
    chk_eq("b idle", 32'(ifb.done), 32'h0);

    // 2x8 array: eight drain cycles
    ifc.resReady = 1'b1;
    ifc.numTiles = 4'd1;
    ifc.startSys = 1'b1;
    tick();
    ifc.startSys = 1'b0;
    for (int t = 0; t <= 12; t++) begin
      chk_eq($sformatf("c addrInc t%0d", t), 32'(ifc.addrInc), 32'(t < 4));
      chk_eq($sformatf("c latCnt t%0d", t), 32'(ifc.latCnt), (t >= 4 && t < 12) ? t - 4 : 0);
      chk_eq($sformatf("c resValid t%0d", t), 32'(ifc.resValid), 32'(t == 12));
      if (t == 0) chk_eq("c psum t0", 32'(ifc.rstnPsum), 32'hFFFE);
      if (t == 8) chk_eq("c psum t8", 32'(ifc.rstnPsum), 32'h7FFF);
      if (t < 12) tick();
    end
    tick();
    chk_eq("c done", 32'(ifc.done), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
